// File: rtl/flappy_game_ctrl_if.sv
// Game-controller <-> renderer bundle: per-frame strobes/inputs in, drawable coordinates out.
// pipe_x packs pipe i at [10i+9:10i], gap_y packs gap i at [9i+8:9i].
interface flappy_game_ctrl_if;
    localparam int unsigned YW = 9;
    localparam int unsigned XW = 10;
    localparam int unsigned NP = 4;

    logic               frame_tick;
    logic               flap;
    logic               collide;
    logic [YW-1:0]      bird_y;
    logic [NP*XW-1:0]   pipe_x;
    logic [NP*YW-1:0]   gap_y;
    logic [7:0]         score;
    logic [1:0]         state;

    modport master (
        input  frame_tick, flap, collide,
        output bird_y, pipe_x, gap_y, score, state
    );

    modport slave (
        output frame_tick, flap, collide,
        input  bird_y, pipe_x, gap_y, score, state
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Per-frame flappy-bird state engine: bird physics, scrolling pipes, score, IDLE/PLAY/DEAD FSM.
// Build macro GOD_MODE_EN: collisions and floor contact never kill; bird rests on the floor.
module flappy_game_ctrl #(
    parameter int unsigned BIRD_Y_INIT  = 225,
    parameter int unsigned BIRD_X       = 100,
    parameter int unsigned BIRD_H       = 30,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned FLAP_VEL     = 6,
    parameter int unsigned MAX_FALL     = 8,
    parameter int unsigned PIPE_SPEED   = 1,
    parameter int unsigned PIPE_SPACING = 160,
    parameter int unsigned DEAD_FRAMES  = 60
) (
    input  logic               clk,
    input  logic               reset,
    flappy_game_ctrl_if.master bus
);
    localparam int unsigned YW        = 9;
    localparam int unsigned YSW       = YW + 2;
    localparam int unsigned XW        = 10;
    localparam int unsigned VW        = 6;
    localparam int unsigned VSW       = VW + 1;
    localparam int unsigned SW        = 8;
    localparam int unsigned SSW       = SW + 1;
    localparam int unsigned CW        = 7;
    localparam int unsigned NP        = 4;
    localparam int unsigned LW        = 16;
    localparam int unsigned FLOOR_Y   = 479 - BIRD_H;
    localparam int unsigned SCORE_MAX = 255;

    localparam logic signed [YSW-1:0] FLOOR_S    = YSW'(FLOOR_Y);
    localparam logic signed [VW-1:0]  FLAP_V     = -VW'(FLAP_VEL);
    localparam logic signed [VSW-1:0] MAX_FALL_W = VSW'(MAX_FALL);
    localparam logic [XW-1:0]         WRAP_ADD   = XW'(4 * PIPE_SPACING - PIPE_SPEED);
    localparam logic [LW-1:0]         LFSR_SEED  = 16'hACE1;

    localparam logic [NP-1:0][XW-1:0] PIPE_INIT = {
        XW'(520 + 3 * PIPE_SPACING), XW'(520 + 2 * PIPE_SPACING),
        XW'(520 + PIPE_SPACING),     XW'(520)
    };
    localparam logic [NP-1:0][YW-1:0] GAP_INIT = {YW'(240), YW'(180), YW'(300), YW'(100)};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [YW-1:0]           bird_y_q, bird_y_d;
    logic signed [VW-1:0]    vel_q, vel_d;
    logic [NP-1:0][XW-1:0]   pipe_x_q, pipe_x_d, pipe_nx;
    logic [NP-1:0][YW-1:0]   gap_y_q, gap_y_d, gap_nx;
    logic [SW-1:0]           score_q, score_d;
    logic [CW-1:0]           dead_cnt_q, dead_cnt_d;
    logic                    flap_pend_q, flap_pend_d;
    logic                    hit_pend_q, hit_pend_d;
    logic                    flap_prev_q;
    logic [LW-1:0]           lfsr_q, lfsr_d;

    logic                    flap_now;
    logic                    hit_now;
    logic                    floor_hit;
    logic signed [YSW-1:0]   y_sum;
    logic [YW-1:0]           y_clamp;
    logic signed [VSW-1:0]   vel_sum;
    logic signed [VW-1:0]    vel_grav;
    logic [2:0]              cross_cnt;
    logic [SSW-1:0]          score_sum;
    logic [SW-1:0]           score_sat;

    // Pending events include this cycle's input so a same-cycle tick consumes them.
    assign flap_now = flap_pend_q | (bus.flap & ~flap_prev_q);
    assign hit_now  = hit_pend_q | ((state_q == ST_PLAY) & bus.collide);
    assign lfsr_d   = {lfsr_q[LW-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bird_y_q    <= YW'(BIRD_Y_INIT);
            vel_q       <= '0;
            pipe_x_q    <= PIPE_INIT;
            gap_y_q     <= GAP_INIT;
            score_q     <= '0;
            dead_cnt_q  <= '0;
            flap_pend_q <= 1'b0;
            hit_pend_q  <= 1'b0;
            flap_prev_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            pipe_x_q    <= pipe_x_d;
            gap_y_q     <= gap_y_d;
            score_q     <= score_d;
            dead_cnt_q  <= dead_cnt_d;
            flap_pend_q <= flap_pend_d;
            hit_pend_q  <= hit_pend_d;
            flap_prev_q <= bus.flap;
            lfsr_q      <= lfsr_d;
        end
    end

    // One PLAY frame worth of motion, evaluated from the current registered state.
    always_comb begin
        y_sum = $signed({2'b00, bird_y_q}) + $signed({{(YSW - VW){vel_q[VW-1]}}, vel_q});
        floor_hit = (y_sum >= FLOOR_S);
        if (y_sum[YSW-1]) begin
            y_clamp = '0;
        end else if (floor_hit) begin
            y_clamp = YW'(FLOOR_Y);
        end else begin
            y_clamp = y_sum[YW-1:0];
        end

        vel_sum = $signed({vel_q[VW-1], vel_q}) + $signed(VSW'(GRAVITY));
        if (vel_sum > MAX_FALL_W) begin
            vel_grav = VW'(MAX_FALL);
        end else begin
            vel_grav = vel_sum[VW-1:0];
        end

        cross_cnt = '0;
        for (int i = 0; i < int'(NP); i++) begin
            gap_nx[i] = gap_y_q[i];
            if (pipe_x_q[i] < XW'(PIPE_SPEED)) begin
                pipe_nx[i] = pipe_x_q[i] + WRAP_ADD;
                gap_nx[i]  = YW'(40) + YW'(lfsr_q[7:0]);
            end else begin
                pipe_nx[i] = pipe_x_q[i] - XW'(PIPE_SPEED);
            end
            if ((pipe_x_q[i] > XW'(BIRD_X)) && (pipe_nx[i] <= XW'(BIRD_X))) begin
                cross_cnt = cross_cnt + 3'd1;
            end
        end

        score_sum = {1'b0, score_q} + SSW'(cross_cnt);
        if (score_sum > SSW'(SCORE_MAX)) begin
            score_sat = SW'(SCORE_MAX);
        end else begin
            score_sat = score_sum[SW-1:0];
        end
    end

    // Game FSM: everything except event capture moves only on frame_tick.
    always_comb begin
        state_d     = state_q;
        bird_y_d    = bird_y_q;
        vel_d       = vel_q;
        pipe_x_d    = pipe_x_q;
        gap_y_d     = gap_y_q;
        score_d     = score_q;
        dead_cnt_d  = dead_cnt_q;
        flap_pend_d = flap_now;
        hit_pend_d  = (state_q == ST_PLAY) ? hit_now : 1'b0;

        if (bus.frame_tick) begin
            flap_pend_d = 1'b0;
            hit_pend_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick && flap_now) begin
                    state_d = ST_PLAY;
                    vel_d   = FLAP_V;
                end
            end
            ST_PLAY: begin
                if (bus.frame_tick) begin
                    bird_y_d = y_clamp;
                    vel_d    = flap_now ? FLAP_V : vel_grav;
                    pipe_x_d = pipe_nx;
                    gap_y_d  = gap_nx;
                    score_d  = score_sat;
`ifdef GOD_MODE_EN
                    if (floor_hit && !flap_now) begin
                        vel_d = '0;
                    end
`else
                    if (hit_now || floor_hit) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = '0;
                    end
`endif
                end
            end
            ST_DEAD: begin
                if (bus.frame_tick) begin
                    if ((dead_cnt_q >= CW'(DEAD_FRAMES)) && flap_now) begin
                        state_d    = ST_IDLE;
                        bird_y_d   = YW'(BIRD_Y_INIT);
                        vel_d      = '0;
                        pipe_x_d   = PIPE_INIT;
                        gap_y_d    = GAP_INIT;
                        score_d    = '0;
                        dead_cnt_d = '0;
                    end else if (dead_cnt_q < CW'(DEAD_FRAMES)) begin
                        dead_cnt_d = dead_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.bird_y = bird_y_q;
    assign bus.pipe_x = pipe_x_q;
    assign bus.gap_y  = gap_y_q;
    assign bus.score  = score_q;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed vector table, hand-written corner sequences and
// randomized play checked every clock against a rule-level game model.
module tb_flappy_game_ctrl;
    localparam int BIRD_Y_INIT  = 225;
    localparam int BIRD_X       = 100;
    localparam int FLOOR        = 449;
    localparam int GRAVITY      = 1;
    localparam int FLAP_VEL     = 6;
    localparam int MAX_FALL     = 8;
    localparam int PIPE_SPEED   = 1;
    localparam int PIPE_SPACING = 160;
    localparam int DEAD_FRAMES  = 60;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    flappy_game_ctrl_if bus ();
    flappy_game_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit tick;
        bit fl;
        bit co;
        int st;
        int y;
        int p0;
    } vec_t;
    vec_t vecs[12];

    // Reference game state, kept as plain integers.
    int          m_state, m_y, m_vel, m_score, m_dcnt;
    int          m_px[4];
    int          m_gap[4];
    bit          m_fp, m_hp, m_fprev;
    logic [15:0] m_lfsr;

    function automatic void model_restart();
        m_state = 0;
        m_y     = BIRD_Y_INIT;
        m_vel   = 0;
        m_score = 0;
        m_dcnt  = 0;
        m_fp    = 1'b0;
        m_hp    = 1'b0;
        for (int i = 0; i < 4; i++) m_px[i] = 520 + i * PIPE_SPACING;
        m_gap[0] = 100; m_gap[1] = 300; m_gap[2] = 180; m_gap[3] = 240;
    endfunction

    function automatic void model_clk(bit rst_n, bit tick, bit fl, bit co);
        int ny;
        int nx;
        int lf_low;
        bit on_floor;
        if (!rst_n) begin
            model_restart();
            m_lfsr  = 16'hACE1;
            m_fprev = 1'b0;
            return;
        end
        lf_low = int'(m_lfsr[7:0]);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (fl && !m_fprev) m_fp = 1'b1;
        m_fprev = fl;
        if (m_state == 1 && co) m_hp = 1'b1;
        if (!tick) return;
        if (m_state == 0) begin
            if (m_fp) begin
                m_state = 1;
                m_vel   = -FLAP_VEL;
            end
        end else if (m_state == 1) begin
            ny       = m_y + m_vel;
            on_floor = (ny >= FLOOR);
            m_y      = (ny < 0) ? 0 : ((ny > FLOOR) ? FLOOR : ny);
            if (m_fp) m_vel = -FLAP_VEL;
            else      m_vel = (m_vel + GRAVITY > MAX_FALL) ? MAX_FALL : m_vel + GRAVITY;
            for (int i = 0; i < 4; i++) begin
                nx = m_px[i] - PIPE_SPEED;
                if (m_px[i] < PIPE_SPEED) begin
                    nx       = m_px[i] + 4 * PIPE_SPACING - PIPE_SPEED;
                    m_gap[i] = 40 + lf_low;
                end
                if (m_px[i] > BIRD_X && nx <= BIRD_X && m_score < 255) m_score++;
                m_px[i] = nx;
            end
`ifdef GOD_MODE_EN
            if (on_floor && !m_fp) m_vel = 0;
`else
            if (m_hp || on_floor) begin
                m_state = 2;
                m_dcnt  = 0;
            end
`endif
        end else begin
            if (m_dcnt >= DEAD_FRAMES && m_fp) model_restart();
            else m_dcnt++;
        end
        m_fp = 1'b0;
        m_hp = 1'b0;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("state", int'(bus.state), m_state);
        cmp("bird_y", int'(bus.bird_y), m_y);
        cmp("score", int'(bus.score), m_score);
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("pipe_x[%0d]", i), int'(bus.pipe_x[10*i +: 10]), m_px[i]);
            cmp($sformatf("gap_y[%0d]", i), int'(bus.gap_y[9*i +: 9]), m_gap[i]);
        end
    endtask

    task automatic step(input bit tick, input bit fl, input bit co);
        bus.frame_tick = tick;
        bus.flap       = fl;
        bus.collide    = co;
        @(posedge clk);
        model_clk(reset, tick, fl, co);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle;
        bit fl;
        int g;

        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;
        bus.collide    = 1'b0;
        reset          = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 225, 520};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 0, 225, 520};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 225, 520};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1, 225, 520};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1, 219, 519};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1, 214, 518};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1, 214, 518};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1, 210, 517};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1, 204, 516};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1, 199, 515};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1, 193, 514};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1, 188, 513};

        do_reset(2);
        cmp("reset state", int'(bus.state), 0);
        cmp("reset bird_y", int'(bus.bird_y), 225);
        cmp("reset pipe_x[3]", int'(bus.pipe_x[39:30]), 1000);
        cmp("reset score", int'(bus.score), 0);

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].tick, vecs[v].fl, vecs[v].co);
            cmp($sformatf("vec%0d state", v), int'(bus.state), vecs[v].st);
            cmp($sformatf("vec%0d bird_y", v), int'(bus.bird_y), vecs[v].y);
            cmp($sformatf("vec%0d pipe_x[0]", v), int'(bus.pipe_x[9:0]), vecs[v].p0);
        end

`ifndef GOD_MODE_EN
        // Free fall to the floor.
        for (int k = 0; k < 300 && int'(bus.state) != 2; k++) step(1'b1, 1'b0, 1'b0);
        cmp("fall state", int'(bus.state), 2);
        cmp("fall bird_y", int'(bus.bird_y), FLOOR);
        step(1'b0, 1'b0, 1'b0);

        // DEAD hold window: flaps on ticks 10 and 60 are dropped, tick 61 restarts.
        for (int k = 1; k <= 9; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("dead tick10 flap", int'(bus.state), 2);
        for (int k = 11; k <= 59; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("dead tick60 flap", int'(bus.state), 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("dead exit state", int'(bus.state), 0);
        cmp("dead exit bird_y", int'(bus.bird_y), 225);
        cmp("dead exit pipe_x[0]", int'(bus.pipe_x[9:0]), 520);
        cmp("dead exit pipe_x[3]", int'(bus.pipe_x[39:30]), 1000);
        cmp("dead exit gap_y[1]", int'(bus.gap_y[17:9]), 300);
        cmp("dead exit score", int'(bus.score), 0);

        // One-clock collide between ticks kills on the next tick.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("collide play", int'(bus.state), 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        cmp("collide before tick", int'(bus.state), 1);
        step(1'b1, 1'b0, 1'b0);
        cmp("collide dead", int'(bus.state), 2);
        for (int k = 1; k <= 60; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("collide restart", int'(bus.state), 0);
`else
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b1);
        cmp("god state", int'(bus.state), 1);
        cmp("god bird_y", int'(bus.bird_y), FLOOR);
`endif

        // Score crossing and pipe wrap from a fresh game.
        do_reset(2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 521; k++) begin
            step(1'b0, (m_y >= 250 && m_vel >= 0), 1'b0);
            step(1'b1, 1'b0, 1'b0);
            if (k == 419) begin
                cmp("pre-cross pipe_x[0]", int'(bus.pipe_x[9:0]), 101);
                cmp("pre-cross score", int'(bus.score), 0);
            end
            if (k == 420) begin
                cmp("cross pipe_x[0]", int'(bus.pipe_x[9:0]), 100);
                cmp("cross score", int'(bus.score), 1);
            end
            if (k == 520) cmp("pre-wrap pipe_x[0]", int'(bus.pipe_x[9:0]), 0);
            if (k == 521) begin
                cmp("wrap pipe_x[0]", int'(bus.pipe_x[9:0]), 639);
                g = int'(bus.gap_y[8:0]);
                cmp("wrap gap_y[0] in 40..295", int'(g >= 40 && g <= 295), 1);
                cmp("wrap state", int'(bus.state), 1);
            end
        end

        // Randomized play with sparse ticks, flaps and collisions.
        for (int f = 0; f < 2500; f++) begin
            idle = int'($urandom_range(0, 3));
            for (int k = 0; k < idle; k++)
                step(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 599) == 0));
            if (m_state == 1) fl = (m_y >= 250 && m_vel >= 0) || ($urandom_range(0, 19) == 0);
            else              fl = ($urandom_range(0, 7) == 0);
            step(1'b0, fl, ($urandom_range(0, 599) == 0));
            step(1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 599) == 0));
        end

        // Reset between a flap and its tick drops the pending flap.
        do_reset(2);
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        cmp("reset drops flap", int'(bus.state), 0);
        cmp("reset drops flap bird_y", int'(bus.bird_y), 225);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
